// File: rtl/lii_pkg.sv
// LII stream packer shared types: id width, lane count, FSM states.
// Imported by the arbiter and the packer top.
package lii_pkg;

  localparam int LII_ID_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GATHER,
    ST_SEND
  } lii_state_t;

  function automatic int lii_lanes(input int pw, input int dw);
    return pw / dw;
  endfunction

endpackage

// File: rtl/lii_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from last winner + 1.
// The pointer advances only when upd commits the current grant.
module lii_rr_arbiter
  import lii_pkg::*;
#(
  parameter  int NIN = 2,
  localparam int GW  = (NIN > 1) ? $clog2(NIN) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NIN-1:0] req,
  input  logic           upd,
  output logic [NIN-1:0] gnt,
  output logic [GW-1:0]  gnt_idx,
  output logic           any
);

  logic [GW-1:0] last;

  // First requester at or after last+1, wrapping.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int off = 1; off <= NIN; off++) begin
      if (!any && req[(int'(last) + off) % NIN]) begin
        any = 1'b1;
        gnt[(int'(last) + off) % NIN] = 1'b1;
        gnt_idx = GW'((int'(last) + off) % NIN);
      end
    end
  end

  // Reset pointer to NIN-1 so stream 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= GW'(NIN - 1);
    end else if (upd && any) begin
      last <= gnt_idx;
    end
  end

endmodule

// File: rtl/lii_stream_packer.sv
// Packs NIN DW-bit streams into PW-bit phy words, one stream per packet.
// Define LII_PACK_CE_EN to gate ce while any stream is back-pressured.
module lii_stream_packer
  import lii_pkg::*;
#(
  parameter int           NIN      = 2,
  parameter int           DW       = 8,
  parameter int           PW       = 64,
  parameter logic [7:0]   SRC_ID   = 8'd0,
  parameter logic [7:0]   DST_BASE = 8'd0
) (
  input  logic                aclk,
  input  logic                arst,
  input  logic [NIN*DW-1:0]   s_tdata,
  input  logic [NIN-1:0]      s_tvalid,
  input  logic [NIN-1:0]      s_tlast,
  output logic [NIN-1:0]      s_tready,
  output logic [PW-1:0]       lii_out_tdata,
  output logic [PW/DW-1:0]    lii_out_tkeep,
  output logic                lii_out_tvalid,
  output logic                lii_out_tlast,
  input  logic                lii_out_tready,
  output logic [LII_ID_W-1:0] lii_out_src,
  output logic [LII_ID_W-1:0] lii_out_dst,
  output logic                ce
);

  localparam int K  = lii_lanes(PW, DW);
  localparam int LW = (K > 1) ? $clog2(K) : 1;
  localparam int GW = (NIN > 1) ? $clog2(NIN) : 1;

  lii_state_t     st, st_n;
  logic [LW-1:0]  lane_cnt;
  logic [GW-1:0]  gidx;
  logic [NIN-1:0] gsel;
  logic [PW-1:0]  data_r;
  logic [K-1:0]   keep_r;
  logic           last_r;

  logic [NIN-1:0] arb_gnt;
  logic [GW-1:0]  arb_idx;
  logic           arb_any;
  logic           arb_upd;

  logic           beat;
  logic [DW-1:0]  beat_data;
  logic           beat_last;
  logic           word_end;
  logic           send_hs;

  lii_rr_arbiter #(.NIN(NIN)) u_arb (
    .clk     (aclk),
    .rst     (arst),
    .req     (s_tvalid),
    .upd     (arb_upd),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  assign beat_data = s_tdata[gidx*DW +: DW];
  assign beat_last = s_tlast[gidx];
  assign beat      = (st == ST_GATHER) && s_tvalid[gidx];
  assign word_end  = (lane_cnt == LW'(K - 1)) || beat_last;
  assign send_hs   = (st == ST_SEND) && lii_out_tready;
  assign arb_upd   = (st == ST_IDLE) && arb_any;

  assign s_tready       = (st == ST_GATHER) ? gsel : '0;
  assign lii_out_tvalid = (st == ST_SEND);
  assign lii_out_tdata  = data_r;
  assign lii_out_tkeep  = keep_r;
  assign lii_out_tlast  = last_r;
  assign lii_out_src    = SRC_ID;
  assign lii_out_dst    = DST_BASE + LII_ID_W'(gidx);

`ifdef LII_PACK_CE_EN
  assign ce = ~|(s_tvalid & ~s_tready);
`else
  assign ce = 1'b1;
`endif

  // State register.
  always_ff @(posedge aclk) begin
    if (arst) begin
      st <= ST_IDLE;
    end else begin
      st <= st_n;
    end
  end

  // Next state: grant, fill lanes, hold word until accepted.
  always_comb begin
    st_n = st;
    unique case (st)
      ST_IDLE: begin
        if (arb_any) st_n = ST_GATHER;
      end
      ST_GATHER: begin
        if (beat && word_end) st_n = ST_SEND;
      end
      ST_SEND: begin
        if (lii_out_tready) begin
          st_n = last_r ? ST_IDLE : ST_GATHER;
        end
      end
      default: st_n = ST_IDLE;
    endcase
  end

  // Grant capture, lane fill and word clear after handshake.
  always_ff @(posedge aclk) begin
    if (arst) begin
      lane_cnt <= '0;
      gidx     <= '0;
      gsel     <= '0;
      data_r   <= '0;
      keep_r   <= '0;
      last_r   <= 1'b0;
    end else begin
      if (arb_upd) begin
        gidx     <= arb_idx;
        gsel     <= arb_gnt;
        lane_cnt <= '0;
        data_r   <= '0;
        keep_r   <= '0;
        last_r   <= 1'b0;
      end
      if (beat) begin
        data_r[int'(lane_cnt)*DW +: DW] <= beat_data;
        keep_r[lane_cnt] <= 1'b1;
        lane_cnt <= lane_cnt + LW'(1);
        last_r   <= beat_last;
      end
      if (send_hs) begin
        lane_cnt <= '0;
        data_r   <= '0;
        keep_r   <= '0;
        last_r   <= 1'b0;
        if (last_r) gsel <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lii_stream_packer.sv
// Scoreboard bench for lii_stream_packer (NIN=2, DW=8, PW=64).
// Expected words are queued as packets are pushed, checked on handshake.
`timescale 1ns/1ps
module tb_lii_stream_packer;

  localparam int NIN = 2;
  localparam int DW  = 8;
  localparam int PW  = 64;
  localparam int K   = PW / DW;
  localparam logic [7:0] SRC = 8'h5A;
  localparam logic [7:0] DB  = 8'h10;

  typedef struct {
    logic [PW-1:0] d;
    logic [K-1:0]  k;
    logic          l;
    logic [7:0]    dst;
  } exp_t;

  logic              aclk = 1'b0;
  logic              arst;
  logic [NIN*DW-1:0] s_tdata;
  logic [NIN-1:0]    s_tvalid;
  logic [NIN-1:0]    s_tlast;
  logic [NIN-1:0]    s_tready;
  logic [PW-1:0]     lii_out_tdata;
  logic [K-1:0]      lii_out_tkeep;
  logic              lii_out_tvalid;
  logic              lii_out_tlast;
  logic              lii_out_tready;
  logic [7:0]        lii_out_src;
  logic [7:0]        lii_out_dst;
  logic              ce;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  exp_t       exp_q[$];
  logic [DW:0] bq [NIN][$];
  int         acc_cnt [NIN];
  int         hs_cyc[$];

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  lii_stream_packer #(
    .NIN(NIN), .DW(DW), .PW(PW),
    .SRC_ID(SRC), .DST_BASE(DB)
  ) dut (
    .aclk           (aclk),
    .arst           (arst),
    .s_tdata        (s_tdata),
    .s_tvalid       (s_tvalid),
    .s_tlast        (s_tlast),
    .s_tready       (s_tready),
    .lii_out_tdata  (lii_out_tdata),
    .lii_out_tkeep  (lii_out_tkeep),
    .lii_out_tvalid (lii_out_tvalid),
    .lii_out_tlast  (lii_out_tlast),
    .lii_out_tready (lii_out_tready),
    .lii_out_src    (lii_out_src),
    .lii_out_dst    (lii_out_dst),
    .ce             (ce)
  );

  // Per-stream source: present queue head, pop on accepted beat.
  initial begin
    logic [NIN-1:0] acc;
    logic [DW:0]    tmp;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    for (int i = 0; i < NIN; i++) acc_cnt[i] = 0;
    forever begin
      @(negedge aclk);
      acc = s_tvalid & s_tready;
      @(posedge aclk);
      #1;
      for (int i = 0; i < NIN; i++) begin
        if (acc[i] && bq[i].size() > 0) begin
          tmp = bq[i].pop_front();
          acc_cnt[i]++;
        end
        if (bq[i].size() > 0) begin
          tmp = bq[i][0];
          s_tvalid[i] = 1'b1;
          s_tlast[i]  = tmp[DW];
          s_tdata[i*DW +: DW] = tmp[DW-1:0];
        end else begin
          s_tvalid[i] = 1'b0;
          s_tlast[i]  = 1'b0;
          s_tdata[i*DW +: DW] = '0;
        end
      end
    end
  end

  // Output monitor: every phy handshake pops and compares one word.
  initial begin
    exp_t e;
    forever begin
      @(negedge aclk);
      if (arst === 1'b0 && lii_out_tvalid === 1'b1 && lii_out_tready === 1'b1) begin
        hs_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL word_unexpected got d=%h k=%h l=%b dst=%h required no word",
                   lii_out_tdata, lii_out_tkeep, lii_out_tlast, lii_out_dst);
        end else begin
          e = exp_q.pop_front();
          if (lii_out_tdata !== e.d || lii_out_tkeep !== e.k ||
              lii_out_tlast !== e.l || lii_out_dst !== e.dst ||
              lii_out_src !== SRC) begin
            failures++;
            $display("FAIL word got d=%h k=%h l=%b dst=%h src=%h required d=%h k=%h l=%b dst=%h src=%h",
                     lii_out_tdata, lii_out_tkeep, lii_out_tlast, lii_out_dst,
                     lii_out_src, e.d, e.k, e.l, e.dst, SRC);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    lii_out_tready = 1'b1;
    for (int i = 0; i < NIN; i++) bq[i].delete();
    exp_q.delete();
    repeat (2) tick();
    arst = 1'b0;
    tick();
    hs_cyc.delete();
  endtask

  task automatic push_pkt(input int s, input int n, input logic [7:0] base);
    exp_t e;
    int   lane;
    logic [7:0] v;
    e.d = '0;
    e.k = '0;
    e.l = 1'b0;
    e.dst = DB + 8'(s);
    lane = 0;
    for (int j = 0; j < n; j++) begin
      v = base + 8'(j);
      bq[s].push_back({(j == n - 1), v});
      e.d[lane*DW +: DW] = v;
      e.k[lane] = 1'b1;
      lane++;
      if (lane == K || j == n - 1) begin
        e.l = (j == n - 1);
        exp_q.push_back(e);
        e.d = '0;
        e.k = '0;
        lane = 0;
      end
    end
  endtask

  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && exp_q.size() != 0; c++) tick();
    if (exp_q.size() == 0) ok = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge aclk);
    checks++;
    if (lii_out_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL rst_tvalid got %b required 0", lii_out_tvalid);
    end
    checks++;
    if (lii_out_tkeep !== '0) begin
      failures++;
      $display("FAIL rst_tkeep got %h required 00", lii_out_tkeep);
    end
    checks++;
    if (lii_out_tdata !== '0) begin
      failures++;
      $display("FAIL rst_tdata got %h required 0", lii_out_tdata);
    end
    checks++;
    if (lii_out_tlast !== 1'b0) begin
      failures++;
      $display("FAIL rst_tlast got %b required 0", lii_out_tlast);
    end
    checks++;
    if (s_tready !== '0) begin
      failures++;
      $display("FAIL rst_s_tready got %b required 00", s_tready);
    end
    checks++;
    if (ce !== 1'b1) begin
      failures++;
      $display("FAIL rst_ce got %b required 1", ce);
    end
  endtask

  task automatic test_full_word();
    bit ok;
    do_reset();
    push_pkt(0, 8, 8'h01);
    drain(200, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL full_word_timeout got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_short_word();
    bit ok;
    do_reset();
    push_pkt(0, 3, 8'hA1);
    drain(200, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL short_word_timeout got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_rr();
    bit ok;
    do_reset();
    for (int p = 0; p < 4; p++) begin
      push_pkt(0, 1, 8'h20 + 8'(p));
      push_pkt(1, 1, 8'h40 + 8'(p));
    end
    drain(400, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rr_timeout got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_priority();
    bit ok;
    do_reset();
    push_pkt(1, 16, 8'h60);
    repeat (2) tick();
    push_pkt(0, 2, 8'h90);
    drain(400, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL prio_timeout got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_throughput();
    bit ok;
    do_reset();
    push_pkt(0, 24, 8'h01);
    drain(400, ok);
    checks++;
    if (!ok || hs_cyc.size() != 3) begin
      failures++;
      $display("FAIL thru_words got %0d words required 3", hs_cyc.size());
    end else begin
      checks++;
      if (hs_cyc[1] - hs_cyc[0] != K + 1 || hs_cyc[2] - hs_cyc[1] != K + 1) begin
        failures++;
        $display("FAIL thru_spacing got %0d,%0d required %0d",
                 hs_cyc[1] - hs_cyc[0], hs_cyc[2] - hs_cyc[1], K + 1);
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    int n;
    logic [PW-1:0] d0;
    logic [K-1:0]  k0;
    logic          l0;
    logic [7:0]    t0;
    logic          exp_ce;
`ifdef LII_PACK_CE_EN
    exp_ce = 1'b0;
`else
    exp_ce = 1'b1;
`endif
    do_reset();
    lii_out_tready = 1'b0;
    push_pkt(0, 3, 8'hA1);
    push_pkt(1, 1, 8'h77);
    n = 0;
    while (lii_out_tvalid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (lii_out_tvalid !== 1'b1) begin
      failures++;
      $display("FAIL stall_tvalid_timeout got %b required 1", lii_out_tvalid);
    end
    @(negedge aclk);
    d0 = lii_out_tdata;
    k0 = lii_out_tkeep;
    l0 = lii_out_tlast;
    t0 = lii_out_dst;
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      checks++;
      if (lii_out_tvalid !== 1'b1 || lii_out_tdata !== d0 ||
          lii_out_tkeep !== k0 || lii_out_tlast !== l0 || lii_out_dst !== t0) begin
        failures++;
        $display("FAIL stall_stable got v=%b d=%h k=%h required v=1 d=%h k=%h",
                 lii_out_tvalid, lii_out_tdata, lii_out_tkeep, d0, k0);
      end
      checks++;
      if (s_tready !== '0) begin
        failures++;
        $display("FAIL stall_s_tready got %b required 00", s_tready);
      end
      checks++;
      if (ce !== exp_ce) begin
        failures++;
        $display("FAIL stall_ce got %b required %b", ce, exp_ce);
      end
    end
    tick();
    lii_out_tready = 1'b1;
    drain(200, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL stall_timeout got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int start;
    int n;
    do_reset();
    start = acc_cnt[0];
    push_pkt(0, 8, 8'hB0);
    n = 0;
    while (acc_cnt[0] - start < 4 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (acc_cnt[0] - start != 4) begin
      failures++;
      $display("FAIL mid_beats got %0d required 4", acc_cnt[0] - start);
    end
    arst = 1'b1;
    for (int i = 0; i < NIN; i++) bq[i].delete();
    exp_q.delete();
    tick();
    arst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge aclk);
      checks++;
      if (lii_out_tvalid !== 1'b0) begin
        failures++;
        $display("FAIL mid_tvalid got %b required 0", lii_out_tvalid);
      end
    end
    tick();
    push_pkt(0, 1, 8'hC0);
    push_pkt(1, 1, 8'hC1);
    drain(200, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL mid_timeout got %0d pending required 0", exp_q.size());
    end
  endtask

  initial begin
    arst = 1'b1;
    lii_out_tready = 1'b1;
    test_reset();
    test_full_word();
    test_short_word();
    test_rr();
    test_priority();
    test_throughput();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lii_stream_packer.md
LII_STREAM_PACKER -- requirements
Module: lii_stream_packer

Interface
REQ-001 SHALL have parameter NIN, default 2, number of logic input streams (1..8).
REQ-002 SHALL have parameter DW, default 8, logic stream data width.
REQ-003 SHALL have parameter PW, default 64, phy packing width; PW SHALL be an integer multiple of DW; K = PW/DW lanes.
REQ-004 SHALL have parameter SRC_ID, default 0, 8-bit source id stamped on every phy word.
REQ-005 SHALL have parameter DST_BASE, default 0, 8-bit destination id of stream 0; stream i maps to DST_BASE+i.
REQ-006 SHALL have port aclk, input, 1, sole clock; one clock, all logic on rising edge.
REQ-007 SHALL have port arst, input, 1, reset: synchronous, active-high.
REQ-008 SHALL have port s_tdata, input, NIN*DW, logic stream data; stream i in bits [i*DW +: DW].
REQ-009 SHALL have ports s_tvalid, s_tlast, input, NIN each, per-stream valid and end-of-packet.
REQ-010 SHALL have port s_tready, output, NIN, per-stream ready.
REQ-011 SHALL have port lii_out_tdata, output, PW, packed phy word.
REQ-012 SHALL have port lii_out_tkeep, output, K, valid-lane mask.
REQ-013 SHALL have ports lii_out_tvalid, lii_out_tlast, output, 1 each; lii_out_tready, input, 1.
REQ-014 SHALL have ports lii_out_src, lii_out_dst, output, 8 each.
REQ-015 SHALL have port ce, output, 1, kernel clock enable.

Function
REQ-016 SHALL implement FSM IDLE -> GATHER -> SEND -> IDLE|GATHER.
REQ-017 IDLE: SHALL grant round-robin among streams with s_tvalid=1, searching from (last grant+1) mod NIN upward; no requester -> stay IDLE.
REQ-018 GATHER: SHALL assert s_tready only for the granted stream; each accepted beat SHALL be written to lane lane_cnt (lane 0 = bits [DW-1:0]) and lane_cnt incremented.
REQ-019 GATHER SHALL go to SEND on the beat where lane_cnt==K-1 or s_tlast=1; lii_out_tvalid SHALL rise the cycle after that beat (latency 1).
REQ-020 SEND: SHALL hold tdata/tkeep/tlast/src/dst stable with tvalid=1 until lii_out_tready=1; all s_tready SHALL be 0.
REQ-021 Unfilled lanes SHALL be zero with tkeep bit 0; tkeep SHALL be contiguous from lane 0.
REQ-022 lii_out_tlast SHALL equal the s_tlast of the final gathered beat.
REQ-023 On SEND handshake: tlast=1 -> IDLE, grant released; tlast=0 -> GATHER, same stream, lane_cnt=0 (grant held for whole packet).
REQ-024 lii_out_dst SHALL be DST_BASE+grant (8-bit wrap); lii_out_src SHALL be SRC_ID.
REQ-025 Sustained throughput SHALL be K beats per K+1 cycles with tready held 1.
REQ-026 s_tvalid deasserting mid-word SHALL stall GATHER without flushing.

Reset
REQ-027 arst=1 on a clock edge SHALL force IDLE, lane_cnt=0, RR pointer so stream 0 has first priority, tvalid=0, tkeep=0, tdata=0, tlast=0, s_tready=0.
REQ-028 Reset mid-packet SHALL discard the partial word; no phy word SHALL be emitted for it.

Configuration
REQ-029 With LII_PACK_CE_EN defined, ce SHALL be 0 in any cycle where some stream has s_tvalid=1 and s_tready=0, else 1.
REQ-030 Without LII_PACK_CE_EN, ce SHALL be tied to 1.

Structure
REQ-031 Package lii_pkg SHALL hold LII_ID_W=8, lane-count function, and FSM state enum.
REQ-032 Round-robin grant SHALL be sub-module lii_rr_arbiter (NIN requests, one-hot grant, update-on-release input).

Verification
REQ-033 NIN=1,DW=8,PW=64: 8 beats 0x01..0x08, tlast on 8th -> one word 0x0807060504030201, tkeep=0xFF, tlast=1, dst=DST_BASE.
REQ-034 3 beats 0xA1,0xA2,0xA3 with tlast -> tdata=0x0000000000A3A2A1, tkeep=0x07, tlast=1.
REQ-035 NIN=2, both streams continuously valid with 1-beat packets -> grants alternate 0,1,0,1; dst alternates DST_BASE, DST_BASE+1.
REQ-036 lii_out_tready=0 for 10 cycles during SEND -> outputs stable, s_tready=0, ce=0 with LII_PACK_CE_EN, ce=1 without.
REQ-037 16-beat packet on stream 1 while stream 0 valid -> two words from stream 1 (first tlast=0) before any stream-0 word.
REQ-038 arst pulsed after 4 beats gathered -> tvalid stays 0, next packet starts at lane 0 with stream 0 priority.
